clock_step_controller: RTL and testbench
========================================

# clock_step_controller

- Sequences the core clock enable for single-cycle and debug operation.
- Turns a programmable divide ratio and run/step/breakpoint controls into a one-cycle `core_tick` pulse in the `clock_100mhz` domain.
- Sits between the board controls (run switch, step button) and the core.
- Replaces free-running divided clocks with a gated enable, so step and halt never produce runt edges.

## Interface
Parameters:
- DIV_WIDTH, 23, width of the divide-ratio input.
- STEP_WIDTH, 8, width of the step burst length.
- PC_WIDTH, 32, width of program-counter and breakpoint compare.

Ports:
- clock_100mhz  in  1  system clock; the only clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- run_request  in  1  level; 1 = free-run requested, 0 = halt.
- step_button  in  1  raw asynchronous button; each rising edge is one step request.
- step_count  in  STEP_WIDTH  core ticks per step request; 0 is treated as 1.
- divisor  in  DIV_WIDTH  tick period = divisor+1 clock_100mhz cycles.
- core_tick  out  1  registered one-cycle pulse; the core advances only on cycles where it is 1.
- halted  out  1  1 in HALTED and BREAK states.
- tick_total  out  32  ticks issued since reset; wraps at 2^32.
- pc  in  PC_WIDTH  current core PC (breakpoint build only).
- breakpoint_addr  in  PC_WIDTH  breakpoint address (breakpoint build only).
- breakpoint_enable  in  1  arms the breakpoint compare (breakpoint build only).
- breakpoint_hit  out  1  1 while in BREAK (breakpoint build only).

## Operation
- step_button passes through a 2-flop synchronizer, then a rising-edge detector, giving `step_pulse`.
- Period counter `div_cnt` (DIV_WIDTH bits):
  - Advances only in RUN or STEP.
  - A tick is due when `div_cnt >= divisor`; `div_cnt` then returns to 0. Using >= means lowering `divisor` mid-count causes a tick on the next compare rather than a 2^DIV_WIDTH wait.
  - `div_cnt` is cleared on every transition into HALTED or BREAK.
- States:
  - HALTED:
    - run_request=1 → RUN. This takes priority over a same-cycle step_pulse, which is dropped.
    - Otherwise step_pulse → STEP, loading `remaining` = max(step_count,1).
  - RUN:
    - run_request=0 → HALTED. No tick is issued in the cycle the halt is taken.
    - step_pulse is ignored.
  - STEP:
    - Each tick decrements `remaining`. The tick issued with remaining==1 → HALTED.
    - run_request and step_pulse are ignored until the burst completes. A run_request held high then moves HALTED → RUN on the next cycle.
  - BREAK (breakpoint build only):
    - No ticks are issued. Exits to HALTED once run_request=0.
    - step_pulse is ignored.
- Breakpoint: in RUN, when a tick is due and breakpoint_enable=1 and pc==breakpoint_addr, the tick is suppressed and the state moves → BREAK. STEP never checks the breakpoint, so stepping off a breakpoint works.
- tick_total increments by 1 on every issued core_tick.
- reset_n low mid-operation aborts any burst immediately. Values held during reset:
  - core_tick=0
  - halted=1
  - breakpoint_hit=0
  - tick_total=0
  - div_cnt=0
  - remaining=0
  - state HALTED
  - synchronizer flops 0

## Timing
- All outputs are registered; core_tick is never combinational.
- divisor=0: a tick on every cycle while in RUN/STEP. divisor=N: a tick every N+1 cycles.
- First tick after entering RUN or STEP arrives divisor+1 cycles after the state change. The counter starts at 0 on entry.
- step_button rising at cycle 0 (held stable) gives step_pulse at cycle 3 and state STEP at cycle 4.
- run_request falling: state HALTED at the next edge, halted=1 one cycle later. At most one tick already in flight can still be visible.
- Ticks from consecutive bursts never overlap; a step_pulse during STEP is lost, not queued.

## Configuration
- `CLOCK_STEP_CONTROLLER_BREAKPOINT_EN` defined:
  - Ports pc, breakpoint_addr, breakpoint_enable and breakpoint_hit exist.
  - The BREAK state and compare logic are built.
- Undefined:
  - Those ports and the BREAK state are absent.
  - RUN leaves only on run_request=0.
  - All other behaviour is identical.

## Structure
- Shared constants go in config.v:
  - State encodings: HALTED=2'd0, RUN=2'd1, STEP=2'd2, BREAK=2'd3.
  - Default widths.
  - The macro above.
- One sub-module, `button_edge_sync`: 2-flop synchronizer plus rising-edge pulse with reset_n. It is reused for other board buttons.
- FSM, period counter, burst counter and tick_total stay in the top module.

## Test plan
- Reset, then run_request=1, divisor=3 → core_tick on every 4th cycle; tick_total=5 after 20 cycles of RUN.
- HALTED, step_count=0, one button press, divisor=0 → exactly one core_tick, then halted=1.
- HALTED, step_count=5, divisor=2 → 5 ticks spaced 3 cycles apart. A second press mid-burst gives no extra ticks; final tick_total=5.
- RUN with divisor=10 and div_cnt=8, divisor changed to 4 → tick on the next cycle, then every 5 cycles.
- Breakpoint build: RUN, breakpoint_enable=1, pc==breakpoint_addr=32'h0000_0040 → tick suppressed, breakpoint_hit=1, halted=1. run_request=0 then gives HALTED, and a step press gives one tick with the same pc.
- reset_n pulsed low for 1 cycle mid-burst (remaining=3) → core_tick=0 immediately, tick_total=0, and no ticks after release until run or step.

Source files
------------

// File: rtl/clock_step_controller_pkg.sv
// ---------------------------------------------------------------------------
// clock_step_controller_pkg
//
// Shared constants for the clock step controller slice:
//   - default widths for the divide ratio, step burst length and PC compare
//   - width of the running tick counter
//   - controller state encoding (HALTED=0, RUN=1, STEP=2, BREAK=3)
//
// Build option: define CLOCK_STEP_CONTROLLER_BREAKPOINT_EN to add the BREAK
// state and the PC breakpoint compare. Without it BREAK does not exist.
// ---------------------------------------------------------------------------
package clock_step_controller_pkg;

    localparam int DEF_DIV_WIDTH    = 23;
    localparam int DEF_STEP_WIDTH   = 8;
    localparam int DEF_PC_WIDTH     = 32;
    localparam int TICK_TOTAL_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
        , ST_BREAK = 2'd3
`endif
    } ctrl_state_e;

endpackage

// File: rtl/clock_step_controller_if.sv
// ---------------------------------------------------------------------------
// clock_step_controller_if
//
// Groups the board-control inputs and the core-facing outputs of the clock
// step controller. clock_100mhz and reset_n are not part of this bundle.
//
// Signals:
//   run_request        level, 1 = free-run, 0 = halt
//   step_button        raw asynchronous step button
//   step_count         core ticks per step request (0 behaves as 1)
//   divisor            tick period = divisor+1 clock cycles
//   core_tick          one-cycle core enable pulse
//   halted             1 while halted or stopped at a breakpoint
//   tick_total         ticks issued since reset (wrapping)
//   pc, breakpoint_addr, breakpoint_enable, breakpoint_hit
//                      only with CLOCK_STEP_CONTROLLER_BREAKPOINT_EN defined
//
// Modports: master = board/control side, slave = controller.
// ---------------------------------------------------------------------------
interface clock_step_controller_if
    import clock_step_controller_pkg::*;
#(
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
    parameter int STEP_WIDTH = DEF_STEP_WIDTH
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
    , parameter int PC_WIDTH = DEF_PC_WIDTH
`endif
);

    logic                        run_request;
    logic                        step_button;
    logic [STEP_WIDTH-1:0]       step_count;
    logic [DIV_WIDTH-1:0]        divisor;
    logic                        core_tick;
    logic                        halted;
    logic [TICK_TOTAL_WIDTH-1:0] tick_total;
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
    logic [PC_WIDTH-1:0]         pc;
    logic [PC_WIDTH-1:0]         breakpoint_addr;
    logic                        breakpoint_enable;
    logic                        breakpoint_hit;
`endif

    modport master (
        output run_request, step_button, step_count, divisor,
        input  core_tick, halted, tick_total
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
        , output pc, breakpoint_addr, breakpoint_enable,
        input  breakpoint_hit
`endif
    );

    modport slave (
        input  run_request, step_button, step_count, divisor,
        output core_tick, halted, tick_total
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
        , input pc, breakpoint_addr, breakpoint_enable,
        output breakpoint_hit
`endif
    );

endinterface

// File: rtl/clock_step_controller_button_edge_sync.sv
// ---------------------------------------------------------------------------
// button_edge_sync
//
// Two-flop synchronizer followed by a rising-edge detector for a raw board
// button. Produces a registered one-cycle pulse per rising edge. Generic so it
// can be reused for other board buttons.
//
// Ports:
//   clk       sampling clock
//   rst_n     asynchronous active-low reset, clears every flop
//   button_i  raw asynchronous button level
//   pulse_o   one-cycle pulse, three cycles after the button rises
// ---------------------------------------------------------------------------
module button_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pulse_q;

    // meta_q/sync_q form the synchronizer; prev_q holds the previous synced
    // level so the pulse fires once per rising edge regardless of hold time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= button_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_step_controller.sv
// ---------------------------------------------------------------------------
// clock_step_controller
//
// Sequences the core clock enable. Turns run/step controls and a programmable
// divide ratio into a registered one-cycle core_tick pulse, so the core is
// gated by an enable instead of a divided clock and never sees runt edges.
//
// Ports:
//   clock_100mhz  the only clock of the block
//   reset_n       asynchronous active-low reset
//   ctrl          clock_step_controller_if.slave bundle (run_request,
//                 step_button, step_count, divisor, core_tick, halted,
//                 tick_total and, with the breakpoint build, pc,
//                 breakpoint_addr, breakpoint_enable, breakpoint_hit)
//
// Build option: CLOCK_STEP_CONTROLLER_BREAKPOINT_EN adds the BREAK state and
// the PC compare. DIV_WIDTH/STEP_WIDTH must match the interface instance.
// ---------------------------------------------------------------------------
module clock_step_controller
    import clock_step_controller_pkg::*;
#(
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
    parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
    input logic                    clock_100mhz,
    input logic                    reset_n,
    clock_step_controller_if.slave ctrl
);

    ctrl_state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]        div_cnt_q, div_cnt_d;
    logic [STEP_WIDTH-1:0]       remaining_q, remaining_d;
    logic                        tick_d;
    logic                        core_tick_q;
    logic                        halted_q;
    logic [TICK_TOTAL_WIDTH-1:0] tick_total_q;
    logic                        step_pulse;
    logic                        tick_due;
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
    logic                        breakpoint_hit_q;
    logic                        bp_match;
`endif

    button_edge_sync u_step_sync (
        .clk      (clock_100mhz),
        .rst_n    (reset_n),
        .button_i (ctrl.step_button),
        .pulse_o  (step_pulse)
    );

    // >= rather than == so a divisor lowered below the current count still
    // produces a tick on the next compare instead of a full wrap-around.
    assign tick_due = (div_cnt_q >= ctrl.divisor);

`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
    assign bp_match = ctrl.breakpoint_enable && (ctrl.pc == ctrl.breakpoint_addr);
`endif

    // Next-state logic. The period counter only runs in RUN/STEP and is
    // cleared whenever the controller stops, so every entry into RUN or STEP
    // starts a fresh divisor+1 period.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;

        case (state_q)
            ST_HALTED: begin
                div_cnt_d = '0;
                if (ctrl.run_request) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    state_d     = ST_STEP;
                    remaining_d = (ctrl.step_count == '0) ? STEP_WIDTH'(1) : ctrl.step_count;
                end
            end

            ST_RUN: begin
                if (!ctrl.run_request) begin
                    state_d   = ST_HALTED;
                    div_cnt_d = '0;
                end else if (tick_due) begin
                    div_cnt_d = '0;
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
                    // The due tick is swallowed so the core stops before
                    // executing the instruction at the breakpoint address.
                    if (bp_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        tick_d = 1'b1;
                    end
`else
                    tick_d = 1'b1;
`endif
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end

            ST_STEP: begin
                // A burst runs to completion; run and further step presses
                // are not looked at until we are back in HALTED.
                if (tick_due) begin
                    tick_d      = 1'b1;
                    div_cnt_d   = '0;
                    remaining_d = remaining_q - STEP_WIDTH'(1);
                    if (remaining_q == STEP_WIDTH'(1)) begin
                        state_d = ST_HALTED;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end

`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
            ST_BREAK: begin
                div_cnt_d = '0;
                if (!ctrl.run_request) begin
                    state_d = ST_HALTED;
                end
            end
`endif

            default: begin
                state_d   = ST_HALTED;
                div_cnt_d = '0;
            end
        endcase
    end

    // State and output registers. halted/breakpoint_hit follow the registered
    // state, so they lag a state change by one cycle.
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_HALTED;
            div_cnt_q        <= '0;
            remaining_q      <= '0;
            core_tick_q      <= 1'b0;
            halted_q         <= 1'b1;
            tick_total_q     <= '0;
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
            breakpoint_hit_q <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            div_cnt_q        <= div_cnt_d;
            remaining_q      <= remaining_d;
            core_tick_q      <= tick_d;
            tick_total_q     <= tick_total_q + TICK_TOTAL_WIDTH'(tick_d);
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
            halted_q         <= (state_q == ST_HALTED) || (state_q == ST_BREAK);
            breakpoint_hit_q <= (state_q == ST_BREAK);
`else
            halted_q         <= (state_q == ST_HALTED);
`endif
        end
    end

    assign ctrl.core_tick  = core_tick_q;
    assign ctrl.halted     = halted_q;
    assign ctrl.tick_total = tick_total_q;
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
    assign ctrl.breakpoint_hit = breakpoint_hit_q;
`endif

endmodule

// File: tb/tb_clock_step_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_step_controller
//
// Self-checking bench for clock_step_controller. Tick times are predicted from
// the timing rules (button at cycle P -> STEP at P+4, first tick divisor+1
// later, then every divisor+1; RUN entered one cycle after run_request rises)
// and compared against the cycle numbers at which core_tick was seen.
// ---------------------------------------------------------------------------
module tb_clock_step_controller;
    import clock_step_controller_pkg::*;

    logic clock_100mhz;
    logic reset_n;

    int checks;
    int errors;
    int cyc;
    int expTotal;
    int tickQ[$];
    int expQ[$];

    clock_step_controller_if ifc ();

    clock_step_controller dut (
        .clock_100mhz (clock_100mhz),
        .reset_n      (reset_n),
        .ctrl         (ifc.slave)
    );

    initial clock_100mhz = 1'b0;
    always #5 clock_100mhz = ~clock_100mhz;

    // Cycle number, stable when sampled on the falling edge.
    always @(posedge clock_100mhz) cyc <= cyc + 1;

    // Record the cycle of every observed core tick.
    always @(negedge clock_100mhz) begin
        if (ifc.core_tick === 1'b1) tickQ.push_back(cyc);
    end

    // Raise the step button at a falling edge, hold it four cycles, release.
    task automatic pressButton(output int pressCyc);
        @(negedge clock_100mhz);
        ifc.step_button = 1'b1;
        pressCyc = cyc;
        repeat (4) @(negedge clock_100mhz);
        ifc.step_button = 1'b0;
    endtask

    // Reference for one step burst: STEP is entered 4 cycles after the press,
    // the first tick is visible divisor+1 cycles later, then every divisor+1.
    task automatic modelStep(input int p, input int n, input int d);
        int cnt;
        cnt = (n == 0) ? 1 : n;
        for (int k = 0; k < cnt; k++) expQ.push_back(p + 4 + (d + 1) * (k + 1));
        expTotal += cnt;
    endtask

    // Reference for a run window: RUN is entered at p+1, ticks every d+1
    // cycles; run_request dropping at q suppresses anything after cycle q.
    task automatic modelRun(input int p, input int q, input int d);
        int t;
        t = p + 1 + (d + 1);
        while (t <= q) begin
            expQ.push_back(t);
            expTotal++;
            t += d + 1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        ifc.run_request = 1'b0;
        ifc.step_button = 1'b0;
        ifc.step_count  = '0;
        ifc.divisor     = '0;
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
        ifc.pc                = '0;
        ifc.breakpoint_addr   = '1;
        ifc.breakpoint_enable = 1'b0;
`endif
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ifc.core_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_tick: got %0b expected 0", ifc.core_tick); end
        checks++;
        if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL reset_halted: got %0b expected 1", ifc.halted); end
        checks++;
        if (ifc.tick_total !== 32'd0) begin errors++; $display("[TB] FAIL reset_tick_total: got %0d expected 0", ifc.tick_total); end
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
        checks++;
        if (ifc.breakpoint_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_bp_hit: got %0b expected 0", ifc.breakpoint_hit); end
`endif
        repeat (3) @(negedge clock_100mhz);
        reset_n = 1'b1;
        repeat (10) @(negedge clock_100mhz);
        checks++;
        if (tickQ.size() !== 0) begin errors++; $display("[TB] FAIL idle_no_ticks: got %0d ticks expected 0", tickQ.size()); end
        checks++;
        if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL idle_halted: got %0b expected 1", ifc.halted); end
    endtask

    task automatic test_run_divisor();
        int p, q;
        tickQ.delete(); expQ.delete();
        ifc.divisor = 23'd3;
        @(negedge clock_100mhz);
        ifc.run_request = 1'b1;
        p = cyc;
        repeat (21) @(negedge clock_100mhz);
        checks++;
        if (ifc.halted !== 1'b0) begin errors++; $display("[TB] FAIL run_halted_low: got %0b expected 0", ifc.halted); end
        checks++;
        if (ifc.tick_total !== 32'd5) begin errors++; $display("[TB] FAIL run_tick_total_20: got %0d expected 5", ifc.tick_total); end
        ifc.run_request = 1'b0;
        q = cyc;
        @(negedge clock_100mhz);
        checks++;
        if (ifc.halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_lag: got %0b expected 0", ifc.halted); end
        @(negedge clock_100mhz);
        checks++;
        if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_asserted: got %0b expected 1", ifc.halted); end
        repeat (4) @(negedge clock_100mhz);
        modelRun(p, q, 3);
        checks++;
        if (tickQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL run_tick_count: got %0d expected %0d", tickQ.size(), expQ.size()); end
        for (int i = 0; i < tickQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (tickQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL run_tick_time[%0d]: got %0d expected %0d", i, tickQ[i], expQ[i]); end
        end
    endtask

    task automatic test_step_single();
        int p;
        tickQ.delete(); expQ.delete();
        ifc.divisor    = 23'd0;
        ifc.step_count = 8'd0;
        pressButton(p);
        repeat (10) @(negedge clock_100mhz);
        modelStep(p, 0, 0);
        checks++;
        if (tickQ.size() !== 1) begin errors++; $display("[TB] FAIL single_tick_count: got %0d expected 1", tickQ.size()); end
        if (tickQ.size() > 0) begin
            checks++;
            if (tickQ[0] !== expQ[0]) begin errors++; $display("[TB] FAIL single_tick_time: got %0d expected %0d", tickQ[0], expQ[0]); end
        end
        checks++;
        if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL single_halted: got %0b expected 1", ifc.halted); end
        checks++;
        if (ifc.tick_total !== 32'(expTotal)) begin errors++; $display("[TB] FAIL single_tick_total: got %0d expected %0d", ifc.tick_total, expTotal); end
    endtask

    task automatic test_step_burst();
        int p, p2;
        tickQ.delete(); expQ.delete();
        ifc.divisor    = 23'd2;
        ifc.step_count = 8'd5;
        pressButton(p);
        pressButton(p2);
        checks++;
        if (ifc.halted !== 1'b0) begin errors++; $display("[TB] FAIL burst_halted_low: got %0b expected 0", ifc.halted); end
        repeat (30) @(negedge clock_100mhz);
        modelStep(p, 5, 2);
        checks++;
        if (tickQ.size() !== 5) begin errors++; $display("[TB] FAIL burst_tick_count: got %0d expected 5", tickQ.size()); end
        for (int i = 0; i < tickQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (tickQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL burst_tick_time[%0d]: got %0d expected %0d", i, tickQ[i], expQ[i]); end
        end
        checks++;
        if (ifc.tick_total !== 32'(expTotal)) begin errors++; $display("[TB] FAIL burst_tick_total: got %0d expected %0d", ifc.tick_total, expTotal); end
        checks++;
        if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL burst_halted: got %0b expected 1", ifc.halted); end
    endtask

    task automatic test_divisor_change();
        int p;
        tickQ.delete(); expQ.delete();
        ifc.divisor = 23'd10;
        @(negedge clock_100mhz);
        ifc.run_request = 1'b1;
        p = cyc;
        repeat (9) @(negedge clock_100mhz);
        ifc.divisor = 23'd4;
        repeat (13) @(negedge clock_100mhz);
        ifc.run_request = 1'b0;
        repeat (5) @(negedge clock_100mhz);
        expQ.push_back(p + 10);
        expQ.push_back(p + 15);
        expQ.push_back(p + 20);
        expTotal += 3;
        checks++;
        if (tickQ.size() !== 3) begin errors++; $display("[TB] FAIL divchg_tick_count: got %0d expected 3", tickQ.size()); end
        for (int i = 0; i < tickQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (tickQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL divchg_tick_time[%0d]: got %0d expected %0d", i, tickQ[i], expQ[i]); end
        end
        checks++;
        if (ifc.tick_total !== 32'(expTotal)) begin errors++; $display("[TB] FAIL divchg_tick_total: got %0d expected %0d", ifc.tick_total, expTotal); end
    endtask

`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
    task automatic test_breakpoint();
        int p2;
        tickQ.delete(); expQ.delete();
        ifc.divisor           = 23'd2;
        ifc.pc                = 32'h0000_0040;
        ifc.breakpoint_addr   = 32'h0000_0040;
        ifc.breakpoint_enable = 1'b1;
        @(negedge clock_100mhz);
        ifc.run_request = 1'b1;
        repeat (8) @(negedge clock_100mhz);
        checks++;
        if (tickQ.size() !== 0) begin errors++; $display("[TB] FAIL bp_suppressed: got %0d ticks expected 0", tickQ.size()); end
        checks++;
        if (ifc.breakpoint_hit !== 1'b1) begin errors++; $display("[TB] FAIL bp_hit: got %0b expected 1", ifc.breakpoint_hit); end
        checks++;
        if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL bp_halted: got %0b expected 1", ifc.halted); end
        ifc.run_request = 1'b0;
        repeat (3) @(negedge clock_100mhz);
        checks++;
        if (ifc.breakpoint_hit !== 1'b0) begin errors++; $display("[TB] FAIL bp_cleared: got %0b expected 0", ifc.breakpoint_hit); end
        ifc.step_count = 8'd1;
        pressButton(p2);
        repeat (10) @(negedge clock_100mhz);
        modelStep(p2, 1, 2);
        checks++;
        if (tickQ.size() !== 1) begin errors++; $display("[TB] FAIL bp_step_off: got %0d ticks expected 1", tickQ.size()); end
        if (tickQ.size() > 0) begin
            checks++;
            if (tickQ[0] !== expQ[0]) begin errors++; $display("[TB] FAIL bp_step_time: got %0d expected %0d", tickQ[0], expQ[0]); end
        end
        checks++;
        if (ifc.tick_total !== 32'(expTotal)) begin errors++; $display("[TB] FAIL bp_tick_total: got %0d expected %0d", ifc.tick_total, expTotal); end
        ifc.breakpoint_enable = 1'b0;
    endtask
`endif

    task automatic test_random();
        int p, q, n, d, len;
        for (int it = 0; it < 8; it++) begin
            tickQ.delete(); expQ.delete();
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(0, 6);
                d = $urandom_range(0, 4);
                ifc.step_count = 8'(n);
                ifc.divisor    = 23'(d);
                pressButton(p);
                repeat (40) @(negedge clock_100mhz);
                modelStep(p, n, d);
            end else begin
                d   = $urandom_range(0, 5);
                len = $urandom_range(3, 30);
                ifc.divisor = 23'(d);
                @(negedge clock_100mhz);
                ifc.run_request = 1'b1;
                p = cyc;
                repeat (len) @(negedge clock_100mhz);
                ifc.run_request = 1'b0;
                q = cyc;
                repeat (4) @(negedge clock_100mhz);
                modelRun(p, q, d);
            end
            checks++;
            if (tickQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL rand%0d_tick_count: got %0d expected %0d", it, tickQ.size(), expQ.size()); end
            for (int i = 0; i < tickQ.size() && i < expQ.size(); i++) begin
                checks++;
                if (tickQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rand%0d_tick_time[%0d]: got %0d expected %0d", it, i, tickQ[i], expQ[i]); end
            end
            checks++;
            if (ifc.tick_total !== 32'(expTotal)) begin errors++; $display("[TB] FAIL rand%0d_tick_total: got %0d expected %0d", it, ifc.tick_total, expTotal); end
            checks++;
            if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_halted: got %0b expected 1", it, ifc.halted); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int p, seen;
        bit found;
        tickQ.delete(); expQ.delete();
        ifc.divisor    = 23'd2;
        ifc.step_count = 8'd5;
        seen  = 0;
        found = 1'b0;
        pressButton(p);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock_100mhz);
            if (ifc.core_tick === 1'b1) seen++;
            if (seen == 2) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL midburst_two_ticks: got %0d ticks expected 2", seen); end
        #1 reset_n = 1'b0;
        #1;
        expTotal = 0;
        checks++;
        if (ifc.core_tick !== 1'b0) begin errors++; $display("[TB] FAIL midburst_tick_cleared: got %0b expected 0", ifc.core_tick); end
        checks++;
        if (ifc.tick_total !== 32'd0) begin errors++; $display("[TB] FAIL midburst_total_cleared: got %0d expected 0", ifc.tick_total); end
        checks++;
        if (ifc.halted !== 1'b1) begin errors++; $display("[TB] FAIL midburst_halted: got %0b expected 1", ifc.halted); end
        @(negedge clock_100mhz);
        reset_n = 1'b1;
        tickQ.delete();
        repeat (30) @(negedge clock_100mhz);
        checks++;
        if (tickQ.size() !== 0) begin errors++; $display("[TB] FAIL post_reset_no_ticks: got %0d expected 0", tickQ.size()); end
        checks++;
        if (ifc.tick_total !== 32'(expTotal)) begin errors++; $display("[TB] FAIL post_reset_total: got %0d expected %0d", ifc.tick_total, expTotal); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expTotal = 0;
        test_reset();
        test_run_divisor();
        test_step_single();
        test_step_burst();
        test_divisor_change();
`ifdef CLOCK_STEP_CONTROLLER_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_random();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
